// File: rtl/memmap_pkg.sv
// memmap_pkg: clock/TRNG configuration register map and sequencer state encoding.
package memmap_pkg;
  localparam int ADDR_PLLEN     = 0;
  localparam int ADDR_VCODIV    = 1;
  localparam int ADDR_RSTBYP    = 2;
  localparam int ADDR_RATIO0    = 3;
  localparam int ADDR_RATIO1    = 4;
  localparam int ADDR_RATIO2    = 5;
  localparam int ADDR_TRNGSEL0  = 6;
  localparam int ADDR_NOISESEL0 = 14;
  typedef enum logic [3:0] {
    IDLE, WR_PLLOFF, WR_VCODIV, WR_R0, WR_R1, WR_R2,
    SETTLE, WR_PLLON, LOCK_WAIT, DONE, ERROR
  } pll_cfg_state_e;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous level.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] sync_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], d_i};
  assign q_o = sync_q[1];
endmodule

// File: rtl/pll_cfg_seq.sv
// pll_cfg_seq: boot-time PLL configuration write program plus host write-port arbiter.
module pll_cfg_seq import memmap_pkg::*; #(
  parameter int         ADDR_W        = 6,
  parameter int         DATA_W        = 12,
  parameter logic [1:0] DEF_VCODIV    = 2'd0,
  parameter logic [9:0] DEF_RATIO0    = 10'd1,
  parameter logic [9:0] DEF_RATIO1    = 10'd1,
  parameter logic [9:0] DEF_RATIO2    = 10'd1,
  parameter int         SETTLE_CYCLES = 16,
  parameter int         LOCK_TIMEOUT  = 1024,
  parameter bit         AUTO_START    = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pll_lock,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  output logic              host_gnt,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              lock_err
);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  pll_cfg_state_e state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic done_q, done_d, err_q, err_d;
  logic wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic lock_s, idle, go, prog_wr;
  sync_2ff u_lock_sync (.clk(clk), .rst_n(rst_n), .d_i(pll_lock), .q_o(lock_s));
  always_comb begin
    idle     = state_q inside {IDLE, DONE, ERROR};
    // the auto-start edge counts as a start so a host write never collides with WR_PLLOFF
    go       = idle & (start | (state_q == IDLE & AUTO_START));
    host_gnt = rst_n & host_req & idle & ~go;
    state_d  = state_q;
    case (state_q)
      IDLE, DONE, ERROR: state_d = go ? WR_PLLOFF : state_q;
      WR_PLLOFF: state_d = WR_VCODIV;
      WR_VCODIV: state_d = WR_R0;
      WR_R0:     state_d = WR_R1;
      WR_R1:     state_d = WR_R2;
      WR_R2:     state_d = SETTLE;
      SETTLE:    state_d = (settle_q == SW'(SETTLE_CYCLES - 1)) ? WR_PLLON : SETTLE;
      WR_PLLON:  state_d = LOCK_WAIT;
      LOCK_WAIT: state_d = lock_s ? DONE : (tmo_q == TW'(LOCK_TIMEOUT - 1)) ? ERROR : LOCK_WAIT;
      default:   state_d = IDLE;
    endcase
    settle_d = (state_q == SETTLE) ? settle_q + 1'b1 : '0;
    tmo_d    = (state_q == LOCK_WAIT) ? tmo_q + 1'b1 : '0;
    done_d   = go ? 1'b0 : done_q | (state_q == DONE);
    err_d    = go ? 1'b0 : err_q | (state_q == ERROR);
    prog_wr  = state_d inside {WR_PLLOFF, WR_VCODIV, WR_R0, WR_R1, WR_R2, WR_PLLON};
    wr_valid_d = prog_wr | host_gnt;
    wr_addr_d  = !prog_wr ? host_addr :
                 state_d == WR_VCODIV ? ADDR_W'(ADDR_VCODIV) :
                 state_d == WR_R0     ? ADDR_W'(ADDR_RATIO0) :
                 state_d == WR_R1     ? ADDR_W'(ADDR_RATIO1) :
                 state_d == WR_R2     ? ADDR_W'(ADDR_RATIO2) : ADDR_W'(ADDR_PLLEN);
    wr_data_d  = !prog_wr ? host_data :
                 state_d == WR_VCODIV ? DATA_W'(DEF_VCODIV) :
                 state_d == WR_R0     ? DATA_W'(DEF_RATIO0) :
                 state_d == WR_R1     ? DATA_W'(DEF_RATIO1) :
                 state_d == WR_R2     ? DATA_W'(DEF_RATIO2) :
                 state_d == WR_PLLON  ? DATA_W'(1) : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      settle_q   <= '0;
      tmo_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      tmo_q      <= tmo_d;
      done_q     <= done_d;
      err_q      <= err_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = ~idle;
  assign done     = done_q;
  assign lock_err = err_q;
endmodule
